// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: two-stage encoder that packs a normalized sign/scale/mantissa
//   triple into an N-bit fixed-regime posit: sign, RS-bit regime, ES-bit exponent and
//   MANT_W-3 fraction bits. Negative values are stored in two's complement.
// Latency: 2 cycles from an accepted input to out_valid. Throughput: one beat per cycle.
// Backpressure: in_ready = ~out_valid | out_ready. The whole pipe freezes while the
//   output is held, so out_* stay stable during a stall. Bubbles are not collapsed.
// Ports: clk/reset (synchronous, active-high); in_valid/in_ready/in_sign/in_scale/
//   in_mant/in_zero/in_inf on the input side; out_valid/out_ready/out_posit/out_zero/
//   out_inf/out_sat on the output side.
// Build option: define POSIT_ENC_RNE_EN to get round-to-nearest-even. When it is not
//   defined, the encoder truncates and ignores the guard and sticky bits.
module posit_encode_pipe #(
    parameter int N       = 16,
    parameter int ES      = 4,
    parameter int RS      = 2,
    parameter int MANT_W  = 12,
    parameter int SCALE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [SCALE_W-1:0] in_scale,
    input  logic [MANT_W-1:0]  in_mant,
    input  logic               in_zero,
    input  logic               in_inf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_posit,
    output logic               out_zero,
    output logic               out_inf,
    output logic               out_sat
);

    localparam int FRAC_W  = MANT_W - 3;
    // The fixed regime together with the exponent covers scales
    // -2^(RS+ES-1) .. 2^(RS+ES-1)-1.
    localparam int EXP_MAX = (1 << (RS + ES - 1)) - 1;
    localparam int EXP_MIN = -(1 << (RS + ES - 1));

    localparam logic signed [SCALE_W:0] SCALE_MAX = (SCALE_W + 1)'(EXP_MAX);
    localparam logic signed [SCALE_W:0] SCALE_MIN = (SCALE_W + 1)'(EXP_MIN);

    localparam logic [N-1:0]  MAXPOS   = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0]  MINPOS   = {{(N - 1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  NAR      = {1'b1, {(N - 1){1'b0}}};
    localparam logic [RS-1:0] REG_FLIP = {1'b1, {(RS - 1){1'b0}}};

    logic advance;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ------------------------------------------------------------------
    // Stage 1: round and adjust the scale
    // ------------------------------------------------------------------
    logic [FRAC_W-1:0]  frac;
    logic               guard;
    logic               sticky;
    logic               rnd;
    logic [FRAC_W:0]    frac_sum;
    logic signed [SCALE_W:0] scale_ext;
    logic signed [SCALE_W:0] scale_rnd;
    logic [FRAC_W-1:0]  frac_rnd;

    assign frac   = in_mant[MANT_W-2:2];
    assign guard  = in_mant[1];
    assign sticky = in_mant[0];

`ifdef POSIT_ENC_RNE_EN
    // Round to nearest. On a tie, round so that the fraction LSB ends up even.
    assign rnd = guard & (sticky | frac[0]);

    // The hidden bit is always 1 by contract, so the encoder never reads it.
    logic unused_bits;
    assign unused_bits = in_mant[MANT_W-1];
`else
    // Truncation. This matches the packing the multiplier did inline.
    assign rnd = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{in_mant[MANT_W-1], guard, sticky};
`endif

    assign frac_sum  = {1'b0, frac} + {{FRAC_W{1'b0}}, rnd};
    // One extra bit of headroom: an input scale at its maximum cannot wrap on carry.
    assign scale_ext = {in_scale[SCALE_W-1], in_scale};
    // A carry out of the fraction means the value rounded up to the next power of two.
    // Truncation can never produce that carry, but the path is kept for both builds.
    assign scale_rnd = frac_sum[FRAC_W] ? scale_ext + {{SCALE_W{1'b0}}, 1'b1} : scale_ext;
    assign frac_rnd  = frac_sum[FRAC_W] ? '0 : frac_sum[FRAC_W-1:0];

    logic                    s1_valid;
    logic                    s1_sign;
    logic signed [SCALE_W:0] s1_scale;
    logic [FRAC_W-1:0]       s1_frac;
    logic                    s1_zero;
    logic                    s1_inf;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_scale <= '0;
            s1_frac  <= '0;
            s1_zero  <= 1'b0;
            s1_inf   <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= in_sign;
                s1_scale <= scale_rnd;
                s1_frac  <= frac_rnd;
                s1_zero  <= in_zero;
                s1_inf   <= in_inf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: pack the fields, saturate and apply the sign
    // ------------------------------------------------------------------
    logic [RS-1:0] k;
    logic [RS-1:0] regime;
    logic [N-1:0]  mag_fmt;
    logic [N-1:0]  mag;
    logic [N-1:0]  p_posit;
    logic          p_zero;
    logic          p_inf;
    logic          p_sat;

    // The regime is the two's-complement k with its MSB inverted, so the
    // field codes increase monotonically with k.
    assign k       = s1_scale[RS+ES-1:ES];
    assign regime  = k ^ REG_FLIP;
    assign mag_fmt = {1'b0, regime, s1_scale[ES-1:0], s1_frac};

    always_comb begin
        mag     = '0;
        p_posit = '0;
        p_zero  = 1'b0;
        p_inf   = 1'b0;
        p_sat   = 1'b0;
        if (s1_inf) begin
            p_posit = NAR;
            p_inf   = 1'b1;
        end else if (s1_zero) begin
            p_zero  = 1'b1;
        end else begin
            if (s1_scale > SCALE_MAX) begin
                mag   = MAXPOS;
                p_sat = 1'b1;
            end else if (s1_scale < SCALE_MIN) begin
                mag   = MINPOS;
                p_sat = 1'b1;
            end else if (mag_fmt == '0) begin
                // The smallest scale with an empty fraction would encode as zero,
                // so it is clamped to minpos instead.
                mag   = MINPOS;
                p_sat = 1'b1;
            end else begin
                mag   = mag_fmt;
            end
            p_posit = s1_sign ? (~mag + 1'b1) : mag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_posit <= '0;
            out_zero  <= 1'b0;
            out_inf   <= 1'b0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            // A bubble clears the payload so the flags never appear without a valid.
            out_posit <= s1_valid ? p_posit : '0;
            out_zero  <= s1_valid & p_zero;
            out_inf   <= s1_valid & p_inf;
            out_sat   <= s1_valid & p_sat;
        end
    end

endmodule

// File: tb/tb_posit_encode_pipe.sv
module tb_posit_encode_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_scale;
    logic [11:0] in_mant;
    logic        in_zero;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_posit;
    logic        out_zero;
    logic        out_inf;
    logic        out_sat;

    posit_encode_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_scale  (in_scale),
        .in_mant   (in_mant),
        .in_zero   (in_zero),
        .in_inf    (in_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit),
        .out_zero  (out_zero),
        .out_inf   (out_inf),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sign;
        logic [7:0]  scale;
        logic [11:0] mant;
        logic        zero;
        logic        inf;
        logic [15:0] posit;
        logic [2:0]  flags;   // {zero, inf, sat}
    } vec_t;

    typedef struct {
        logic [15:0] posit;
        logic [2:0]  flags;
        int          t_acc;
        int          id;
    } exp_t;

    exp_t exp_q[$];

    function automatic vec_t mk(input logic s, input logic [7:0] sc, input logic [11:0] m,
                                input logic z, input logic i, input logic [15:0] p,
                                input logic [2:0] f);
        vec_t v;
        v.sign = s; v.scale = sc; v.mant = m; v.zero = z; v.inf = i;
        v.posit = p; v.flags = f;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_scale = v.scale;
        in_mant  = v.mant;
        in_zero  = v.zero;
        in_inf   = v.inf;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_scale = 8'h00;
        in_mant  = 12'h000;
        in_zero  = 1'b0;
        in_inf   = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        total++;
        if (out_posit !== 16'h0000) begin bad++; $display("FAIL reset_posit got %h want 0000", out_posit); end
        total++;
        if ({out_zero, out_inf, out_sat} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got %b want 000", {out_zero, out_inf, out_sat});
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_encode();
        vec_t v[$];
        int   idx;
        int   got;
        exp_t e;
        v.push_back(mk(0, 8'd0,   12'h800, 0, 0, 16'h4000, 3'b000));
        v.push_back(mk(1, 8'd0,   12'h800, 0, 0, 16'hC000, 3'b000));
`ifdef POSIT_ENC_RNE_EN
        v.push_back(mk(0, 8'd0,   12'hFFE, 0, 0, 16'h4200, 3'b000));
        v.push_back(mk(0, 8'd0,   12'h806, 0, 0, 16'h4002, 3'b000));
        v.push_back(mk(0, 8'd16,  12'h8FF, 0, 0, 16'h6040, 3'b000));
        v.push_back(mk(0, 8'd31,  12'hFFE, 0, 0, 16'h7FFF, 3'b001));
`else
        v.push_back(mk(0, 8'd0,   12'hFFE, 0, 0, 16'h41FF, 3'b000));
        v.push_back(mk(0, 8'd0,   12'h806, 0, 0, 16'h4001, 3'b000));
        v.push_back(mk(0, 8'd16,  12'h8FF, 0, 0, 16'h603F, 3'b000));
        v.push_back(mk(0, 8'd31,  12'hFFE, 0, 0, 16'h7FFF, 3'b000));
`endif
        v.push_back(mk(0, 8'd0,   12'h80A, 0, 0, 16'h4002, 3'b000));
        v.push_back(mk(0, 8'd40,  12'h800, 0, 0, 16'h7FFF, 3'b001));
        v.push_back(mk(1, 8'hD8,  12'h800, 0, 0, 16'hFFFF, 3'b001)); // -40
        v.push_back(mk(0, 8'hE0,  12'h800, 0, 0, 16'h0001, 3'b001)); // -32
        v.push_back(mk(1, 8'hE0,  12'h804, 0, 0, 16'hFFFF, 3'b000)); // -32, frac 1
        v.push_back(mk(0, 8'd0,   12'h800, 1, 1, 16'h8000, 3'b010));
        v.push_back(mk(0, 8'd0,   12'h800, 1, 0, 16'h0000, 3'b100));
        v.push_back(mk(1, 8'd7,   12'h9F0, 1, 0, 16'h0000, 3'b100));
        v.push_back(mk(1, 8'd5,   12'h800, 0, 1, 16'h8000, 3'b010));
        v.push_back(mk(1, 8'd31,  12'h800, 0, 0, 16'h8200, 3'b000));
        v.push_back(mk(0, 8'hEF,  12'hA04, 0, 0, 16'h1E81, 3'b000)); // -17
        v.push_back(mk(0, 8'hFF,  12'h800, 0, 0, 16'h3E00, 3'b000)); // -1
        v.push_back(mk(0, 8'd32,  12'h800, 0, 0, 16'h7FFF, 3'b001));
        v.push_back(mk(0, 8'hDF,  12'h800, 0, 0, 16'h0001, 3'b001)); // -33
        v.push_back(mk(0, 8'd127, 12'hFFE, 0, 0, 16'h7FFF, 3'b001));
        v.push_back(mk(1, 8'h80,  12'h800, 0, 0, 16'hFFFF, 3'b001)); // -128
        v.push_back(mk(1, 8'd50,  12'h800, 0, 0, 16'h8001, 3'b001));

        out_ready = 1'b1;
        idx = 0;
        got = 0;
        for (int t = 0; t < v.size() + 10 && got < v.size(); t++) begin
            @(negedge clk);
            if (idx < v.size()) apply(v[idx]);
            else idle();
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL encode_extra got %h want no output", out_posit);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    total++;
                    if (out_posit !== e.posit) begin
                        bad++; $display("FAIL encode[%0d]_posit got %h want %h", e.id, out_posit, e.posit);
                    end
                    total++;
                    if ({out_zero, out_inf, out_sat} !== e.flags) begin
                        bad++; $display("FAIL encode[%0d]_flags got %b want %b", e.id,
                                        {out_zero, out_inf, out_sat}, e.flags);
                    end
                    total++;
                    if (cyc !== e.t_acc + 2) begin
                        bad++; $display("FAIL encode[%0d]_latency got %0d want 2", e.id, cyc - e.t_acc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{posit: v[idx].posit, flags: v[idx].flags, t_acc: cyc, id: idx});
                idx++;
            end
        end
        idle();
        total++;
        if (got !== v.size()) begin
            bad++; $display("FAIL encode_count got %0d want %0d", got, v.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        vec_t v[4];
        int   idx;
        int   got;
        int   stall_left;
        bit   started;
        exp_t e;
        for (int i = 0; i < 4; i++)
            v[i] = mk(0, 8'(i), 12'h800, 0, 0, 16'h4000 + 16'(i * 16'h0200), 3'b000);
        idx = 0;
        got = 0;
        stall_left = 0;
        started = 1'b0;
        for (int t = 0; t < 40 && got < 4; t++) begin
            @(negedge clk);
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (idx < 4) apply(v[idx]);
            else idle();
            #1;
            if (out_valid && !out_ready) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
                total++;
                if (exp_q.size() == 0 || out_posit !== exp_q[0].posit) begin
                    bad++; $display("FAIL stall_hold got %h want %h", out_posit,
                                    exp_q.size() > 0 ? exp_q[0].posit : 16'hxxxx);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b2b_extra got %h want no output", out_posit);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    total++;
                    if (out_posit !== e.posit) begin
                        bad++; $display("FAIL b2b[%0d]_posit got %h want %h", e.id, out_posit, e.posit);
                    end
                end
                if (!started) begin
                    started = 1'b1;
                    stall_left = 3;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{posit: v[idx].posit, flags: v[idx].flags, t_acc: cyc, id: idx});
                idx++;
            end
        end
        idle();
        out_ready = 1'b1;
        total++;
        if (got !== 4) begin bad++; $display("FAIL b2b_count got %0d want 4", got); end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_duplicate got out_valid=%b want 0", out_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_flush();
        int seen;
        out_ready = 1'b0;
        @(negedge clk);
        apply(mk(0, 8'd5, 12'h800, 0, 0, 16'h0, 3'b000));
        @(negedge clk);
        apply(mk(1, 8'd6, 12'h800, 0, 0, 16'h0, 3'b000));
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got %b want 0", out_valid); end
        total++;
        if (out_posit !== 16'h0000) begin bad++; $display("FAIL flush_posit got %h want 0000", out_posit); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        apply(mk(0, 8'd2, 12'h800, 0, 0, 16'h0, 3'b000));
        seen = -1;
        for (int t = 1; t <= 6 && seen < 0; t++) begin
            @(negedge clk);
            idle();
            #1;
            if (out_valid) seen = t;
        end
        total++;
        if (seen !== 2) begin bad++; $display("FAIL flush_new_latency got %0d want 2", seen); end
        total++;
        if (out_posit !== 16'h4400) begin bad++; $display("FAIL flush_new_posit got %h want 4400", out_posit); end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_leak got out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_back_to_back();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
